// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point DIF FFT datapath and its loader.
// Complex words pack Re in the upper half and Im in the lower half, each signed Q8.8.
package fft_pkg;

  localparam int CPX_W  = 32;
  localparam int HALF_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = 3;

  // Twiddles W_k = exp(-j*2*pi*k/8) in Q8.8; 0.7071 rounds to 181 (0x00B5).
  localparam logic [CPX_W-1:0] W_0 = 32'h0100_0000;
  localparam logic [CPX_W-1:0] W_1 = 32'h00B5_FF4B;
  localparam logic [CPX_W-1:0] W_2 = 32'h0000_FF00;
  localparam logic [CPX_W-1:0] W_3 = 32'hFF4B_FF4B;

  function automatic logic [CPX_W-1:0] cpx_pack(input logic [HALF_W-1:0] re,
                                                input logic [HALF_W-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream in and parallel frame out, each with its own valid/ready pair.
// slave is the loader side, master is the producer/consumer side.
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic                      s_valid;
  logic                      s_ready;
  logic [CPX_W-1:0]          s_data;
  logic                      frame_valid;
  logic                      frame_ready;
  logic [N_PTS*CPX_W-1:0]    frame_data;

  modport slave (
    input  s_valid, s_data, frame_ready,
    output s_ready, frame_valid, frame_data
  );

  modport master (
    output s_valid, s_data, frame_ready,
    input  s_ready, frame_valid, frame_data
  );

endinterface

// File: rtl/cpx_scale.sv
// Per-component arithmetic right shift of a packed complex word (floor rounding).
// Purely combinational; no handshake, no backpressure.
module cpx_scale
  import fft_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [CPX_W-1:0] din,
  output logic [CPX_W-1:0] dout
);

  logic signed [HALF_W-1:0] re;
  logic signed [HALF_W-1:0] im;
  logic signed [HALF_W-1:0] re_sh;
  logic signed [HALF_W-1:0] im_sh;

  assign re    = din[CPX_W-1:HALF_W];
  assign im    = din[HALF_W-1:0];
  assign re_sh = re >>> SHIFT;
  assign im_sh = im >>> SHIFT;
  assign dout  = cpx_pack(re_sh, im_sh);

endmodule

// File: rtl/fft_frame_loader.sv
// Packs 8 scaled samples into ping-pong banks; frame_valid rises the cycle after the 8th sample.
// s_ready drops only while the write bank is still full or during flush; frame output holds under stall.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int SCALE_SHIFT = 0,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fft_frame_loader_if.slave   bus,
  output logic [CNT_W-1:0]    frame_cnt
);

  logic [N_PTS-1:0][CPX_W-1:0] bank_q [0:1];
  logic [N_PTS-1:0][CPX_W-1:0] bank_d [0:1];
  logic [1:0]                  full_q,    full_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]            wr_idx_q,  wr_idx_d;
  logic [CNT_W-1:0]            cnt_q,     cnt_d;

  logic [CPX_W-1:0]            scaled;
  logic                        s_ready;
  logic                        wr_fire;
  logic                        rd_fire;

  cpx_scale #(.SHIFT(SCALE_SHIFT)) u_scale (
    .din  (bus.s_data),
    .dout (scaled)
  );

  // Ready depends only on registered state and flush, never on s_valid.
  assign s_ready         = !full_q[wr_bank_q] && !flush;
  assign wr_fire         = bus.s_valid && s_ready;
  assign rd_fire         = full_q[rd_bank_q] && bus.frame_ready;

  assign bus.s_ready     = s_ready;
  assign bus.frame_valid = full_q[rd_bank_q];
  assign bus.frame_data  = bank_q[rd_bank_q];
  assign frame_cnt       = cnt_q;

  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    cnt_d     = cnt_q;

    if (flush) begin
      wr_idx_d = '0;
    end

    if (wr_fire) begin
      bank_d[wr_bank_q][wr_idx_q] = scaled;
      if (wr_idx_q == IDX_W'(N_PTS - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    // The write side can only complete the bank the read side is not holding,
    // so the two full-flag updates never touch the same bit.
    if (rd_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      cnt_d             = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      cnt_q     <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench: expected frames are queued as stimulus is issued and popped on each frame handoff.
module tb_fft_frame_loader;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush_s;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt_s;

  fft_frame_loader_if bus ();
  fft_frame_loader_if bus_s ();

  fft_frame_loader #(.SCALE_SHIFT(0), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  fft_frame_loader #(.SCALE_SHIFT(3), .CNT_W(2)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .bus       (bus_s),
    .frame_cnt (frame_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hand = 0;
  int n_hand_s = 0;
  logic [255:0] exp_q   [$];
  logic [255:0] exp_q_s [$];

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  // Monitors: sample at negedge, a handoff occurs at the next posedge.
  always @(negedge clk) begin
    if (rst_n && bus.frame_valid && bus.frame_ready) begin
      n_hand++;
      if (exp_q.size() == 0) chk("unexpected_frame", bus.frame_data, '0);
      else chk("frame", bus.frame_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_s.frame_valid && bus_s.frame_ready) begin
      n_hand_s++;
      if (exp_q_s.size() == 0) chk("unexpected_frame_s", bus_s.frame_data, '0);
      else chk("frame_s", bus_s.frame_data, exp_q_s.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one sample and returns after the posedge that accepts it.
  task automatic send(input bit sel, input logic [31:0] d, output int stalls);
    stalls = 0;
    if (sel) begin bus_s.s_valid = 1'b1; bus_s.s_data = d; end
    else     begin bus.s_valid   = 1'b1; bus.s_data   = d; end
    @(negedge clk);
    while (!(sel ? bus_s.s_ready : bus.s_ready) && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 200) chk("send_timeout", 256'(stalls), 0);
    @(posedge clk);
    #1;
    if (sel) bus_s.s_valid = 1'b0;
    else     bus.s_valid   = 1'b0;
  endtask

  logic [255:0] fa, fb;
  int st, stall_sum, acc, h0;
  logic [31:0] scl_in  [8];
  logic [31:0] scl_out [8];

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_s = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.frame_ready = 1'b0;
    bus_s.s_valid = 1'b0; bus_s.s_data = '0; bus_s.frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state; frame_ready with nothing valid must be ignored.
    bus.frame_ready = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 256'(bus.s_ready), 1);
    chk("rst_frame_valid", 256'(bus.frame_valid), 0);
    chk("rst_frame_data", bus.frame_data, '0);
    chk("rst_frame_cnt", 256'(frame_cnt), 0);
    @(posedge clk); #1;
    chk("ready_ignored_cnt", 256'(frame_cnt), 0);

    // Basic frame: 0x0100_0000 .. 0x0800_0000, natural order.
    fa = '0;
    for (int k = 0; k < 8; k++) fa[32*k +: 32] = {8'(k + 1), 24'h00_0000};
    exp_q.push_back(fa);
    for (int k = 0; k < 8; k++) begin
      send(1'b0, {8'(k + 1), 24'h00_0000}, st);
      if (k == 6) chk("basic_not_valid_at_7", 256'(bus.frame_valid), 0);
    end
    chk("basic_latency_valid", 256'(bus.frame_valid), 1);
    chk("basic_xn0", 256'(bus.frame_data[31:0]), 256'(32'h0100_0000));
    chk("basic_xn7", 256'(bus.frame_data[255:224]), 256'(32'h0800_0000));
    @(posedge clk); #1;
    chk("basic_cnt", 256'(frame_cnt), 1);

    // Backpressure: 24 cycles of s_valid with the consumer stalled.
    bus.frame_ready = 1'b0;
    fa = '0; fb = '0;
    for (int k = 0; k < 8; k++) begin
      fa[32*k +: 32] = {16'h0010 + 16'(k), 16'hFFF0 - 16'(k)};
      fb[32*k +: 32] = {16'h0018 + 16'(k), 16'hFFE8 - 16'(k)};
    end
    exp_q.push_back(fa);
    exp_q.push_back(fb);
    acc = 0;
    for (int c = 0; c < 24; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = {16'h0010 + 16'(acc), 16'hFFF0 - 16'(acc)};
      @(negedge clk);
      if (bus.s_ready) acc++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 256'(acc), 16);
    chk("bp_s_ready_low", 256'(bus.s_ready), 0);
    chk("bp_valid_held", 256'(bus.frame_valid), 1);
    chk("bp_data_stable", bus.frame_data, fa);
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    chk("bp_cnt", 256'(frame_cnt), 2);
    @(negedge clk);
    chk("bp_s_ready_after", 256'(bus.s_ready), 1);
    chk("bp_second_valid", 256'(bus.frame_valid), 1);
    chk("bp_second_data", bus.frame_data, fb);
    @(posedge clk); #1;
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_cnt", 256'(frame_cnt), 3);

    // Simultaneous completion/handoff: 5 frames at full rate.
    for (int f = 0; f < 5; f++) begin
      fa = '0;
      for (int k = 0; k < 8; k++) fa[32*k +: 32] = {16'(16'h2000 + f), 16'(k)};
      exp_q.push_back(fa);
    end
    h0 = n_hand;
    stall_sum = 0;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 8; k++) begin
        send(1'b0, {16'(16'h2000 + f), 16'(k)}, st);
        stall_sum += st;
      end
    @(posedge clk); #1;
    chk("sim_no_stall", 256'(stall_sum), 0);
    chk("sim_handoffs", 256'(n_hand - h0), 5);
    chk("sim_cnt", 256'(frame_cnt), 8);

    // Flush: 3 partial samples dropped; s_ready low during the flush cycle.
    for (int k = 0; k < 3; k++) send(1'b0, 32'hAAAA_0000 + 32'(k), st);
    flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("flush_s_ready", 256'(bus.s_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; bus.s_valid = 1'b0;
    fa = '0;
    for (int k = 0; k < 8; k++) fa[32*k +: 32] = 32'h0C00_0000 + 32'(k);
    exp_q.push_back(fa);
    for (int k = 0; k < 8; k++) send(1'b0, 32'h0C00_0000 + 32'(k), st);
    @(posedge clk); #1;
    chk("flush_cnt", 256'(frame_cnt), 9);

    // Scaling by 3 on the second instance, hand-derived results.
    scl_in  = '{32'hF800_0800, 32'hFFFF_0001, 32'h7FFF_8000, 32'h0007_FFF9,
                32'h0008_FFF8, 32'h0100_0100, 32'h1234_5678, 32'hFF00_FF01};
    scl_out = '{32'hFF00_0100, 32'hFFFF_0000, 32'h0FFF_F000, 32'h0000_FFFF,
                32'h0001_FFFF, 32'h0020_0020, 32'h0246_0ACF, 32'hFFE0_FFE0};
    fa = '0;
    for (int k = 0; k < 8; k++) fa[32*k +: 32] = scl_out[k];
    exp_q_s.push_back(fa);
    bus_s.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(1'b1, scl_in[k], st);
    @(posedge clk); #1;
    chk("scale_cnt", 256'(frame_cnt_s), 1);

    // Counter wrap on the 2-bit instance: 4 handoffs -> 0, 5 -> 1.
    for (int f = 1; f < 5; f++) begin
      fa = '0;
      for (int k = 0; k < 8; k++) fa[32*k +: 32] = {16'(f * 8 + k + 1), 16'(f * 8 + k + 1)};
      exp_q_s.push_back(fa);
      for (int k = 0; k < 8; k++)
        send(1'b1, {16'(8 * (f * 8 + k + 1)), 16'(8 * (f * 8 + k + 1))}, st);
      @(posedge clk); #1;
      if (f == 3) chk("cnt_wrap_zero", 256'(frame_cnt_s), 0);
    end
    chk("cnt_wrap_one", 256'(frame_cnt_s), 1);
    chk("scale_handoffs", 256'(n_hand_s), 5);

    // Reset mid-operation: one bank full plus 4 pending samples.
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 12; k++) send(1'b0, 32'h5555_0000 + 32'(k), st);
    chk("pre_rst_valid", 256'(bus.frame_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(bus.frame_valid), 0);
    chk("mid_rst_data", bus.frame_data, '0);
    chk("mid_rst_cnt", 256'(frame_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 256'(bus.s_ready), 1);
    chk("post_rst_valid", 256'(bus.frame_valid), 0);

    chk("queue_empty", 256'(exp_q.size()), 0);
    chk("queue_s_empty", 256'(exp_q_s.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream stage of the 8-point DIF FFT core.
- Accepts a stream of packed complex samples over a valid/ready handshake and assembles them into 8-sample frames in a ping-pong buffer.
- Presents each complete frame in parallel on xn0..xn7 in natural order, with its own valid/ready handshake.
- Optional per-component pre-scaling leaves headroom for the FFT's growth of up to 8x.

Parameters:
- SCALE_SHIFT, 0, arithmetic right shift applied to each 16-bit Re/Im component on write; legal range 0..3.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards the partially filled frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  32  complex sample: [31:16] Re, [15:0] Im, each signed Q8.8.
- frame_valid  out  1  complete frame presented.
- frame_ready  in  1  FFT side accepts the frame.
- frame_data  out  256  xn_k at [32k+31:32k], k=0..7, with xn0 the first sample received.
- frame_cnt  out  CNT_W  number of frames handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): both banks empty; wr_bank=0, rd_bank=0, wr_idx=0; all bank storage 0; frame_cnt=0; frame_valid=0; frame_data=0; s_ready=1 on the first cycle after release.
- Storage: two banks of 8x32 registers, each with a full flag.
- Write side:
  - s_ready = !full[wr_bank] && !flush. It is a function of registered state and flush only, never of s_valid.
  - On s_valid&&s_ready: bank[wr_bank][wr_idx] <= scale(s_data), then wr_idx++.
  - If wr_idx==7: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
- Scaling: Re and Im are each arithmetic-shifted right by SCALE_SHIFT (sign-extended, truncating toward -inf). No saturation is needed.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_data = bank[rd_bank]; it is muxed from registers with no combinational path from s_data.
  - On frame_valid&&frame_ready: clear full[rd_bank], toggle rd_bank, frame_cnt++.
- Latency: the 8th sample is accepted in cycle t; frame_valid=1 in cycle t+1.
- Throughput: sustains 1 sample/cycle indefinitely when frame_ready is held high.
- Stability: while frame_valid && !frame_ready, frame_data and frame_valid hold constant.
- Both banks full: s_ready=0 until a frame handoff. s_ready rises in the cycle after the handoff.
- Simultaneous completion and handoff in the same cycle: both occur. The bank being read is released while the other bank is marked full; each full flag is updated independently.
- flush: wr_idx <= 0 and the partial samples are abandoned (storage need not be cleared). Full banks and the read side are unaffected. s_ready=0 during the flush cycle, so no sample is lost mid-cycle.
- frame_ready while frame_valid=0: ignored.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- rst_n asserted mid-frame or mid-handoff: immediate return to the reset state; partial and full frames are discarded.

Decomposition:
- Shared package fft_pkg holds:
  - CPX_W=32, HALF_W=16, FRAC_W=8, N_PTS=8, IDX_W=3.
  - Twiddle constants W_0..W_3, shared with the FFT core.
- One sub-module, cpx_scale: parameterized per-component arithmetic shift of a packed complex word, instantiated on the write path.
- Bank storage and control stay in the top module.

Test Plan:
- Basic frame: after reset, SCALE_SHIFT=0, frame_ready=1; send 0x0100_0000,0x0200_0000..0x0800_0000 back-to-back -> frame_valid 1 cycle after the 8th sample; xn0=0x0100_0000, xn7=0x0800_0000; frame_cnt=1.
- Backpressure: frame_ready=0; stream 24 samples with s_valid=1 -> 16 accepted, then s_ready=0; frame_data stays stable. Raise frame_ready for 1 cycle -> frame_cnt=1, s_ready=1 next cycle, and the second frame is presented.
- Simultaneous: frame_ready=1 with continuous input for 5 frames -> no s_ready deassertion, frame_valid every 8 cycles, frame_cnt=5.
- Scaling: SCALE_SHIFT=3; sample 0xF800_0800 (Re=-8.0, Im=8.0) -> stored 0xFF00_0100. Sample 0xFFFF_0001 -> 0xFFFF_0000.
- Flush: send 3 samples, pulse flush with s_valid=1 -> s_ready=0 that cycle. The next 8 samples form a frame whose xn0 is the first post-flush sample.
- Reset mid-operation: one bank full plus 4 samples pending; assert rst_n=0 asynchronously -> frame_valid=0, frame_data=0 and frame_cnt=0 immediately; s_ready=1 after release.
